// File: rtl/direction_input_ctrl.sv
// Push-button front end for the game FSM: synchronise, debounce and edge-detect
// four buttons, then hold one one-hot move command until the consumer takes it.
module direction_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_WIDTH       = 20,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       dir_ready,
    output logic [3:0] direction,
    output logic       dir_valid,
    output logic [3:0] btn_level,
    output logic       dropped
);

    typedef enum logic {
        EMPTY,
        PENDING
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    state_t                 state;
    logic [3:0]             raw_pressed;
    logic [3:0]             in_q;
    logic [3:0]             sync_meta;
    logic [3:0]             sync;
    logic [2:0]             flush;
    logic [3:0]             armed;
    logic [3:0]             btn_level_d;
    logic [CNT_WIDTH-1:0]   cnt [4];
    logic [3:0]             event_vec;
    logic [3:0]             grant;
    logic                   multi;

    assign raw_pressed = BTN_ACTIVE_LOW ? ~{btn_right, btn_left, btn_down, btn_up}
                                        :  {btn_right, btn_left, btn_down, btn_up};

    // Capture register ahead of the two-flop synchroniser sets the press-to-level
    // latency at DEBOUNCE_CYCLES+2; flush marks when sync carries post-reset samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q      <= '0;
            sync_meta <= '0;
            sync      <= '0;
            flush     <= '0;
            armed     <= '0;
        end else begin
            in_q      <= raw_pressed;
            sync_meta <= in_q;
            sync      <= sync_meta;
            flush     <= {flush[1:0], 1'b1};
            // A button only produces events once it has been seen released since reset.
            armed     <= armed | (~sync & {4{flush[2]}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_level_d <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_level[i] <= sync[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
            btn_level_d <= btn_level;
        end
    end

    // Lowest set bit wins: up > down > left > right.
    assign event_vec = btn_level & ~btn_level_d & armed;
    assign grant     = event_vec & (~event_vec + 4'd1);
    assign multi     = |(event_vec & ~grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            direction <= '0;
            dir_valid <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            dropped <= 1'b0;
            case (state)
                EMPTY: begin
                    if (|event_vec) begin
                        direction <= grant;
                        dir_valid <= 1'b1;
                        dropped   <= multi;
                        state     <= PENDING;
                    end
                end
                PENDING: begin
                    if (|event_vec) begin
                        dropped <= 1'b1;
                    end
                    if (dir_ready) begin
                        direction <= '0;
                        dir_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    direction <= '0;
                    dir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Bench for direction_input_ctrl: directed scenarios plus random button activity,
// checked every cycle against a window-based behavioural model.
module tb_direction_input_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b1;
    logic       btn_down = 1'b1;
    logic       btn_left = 1'b1;
    logic       btn_right = 1'b1;
    logic       dir_ready = 1'b0;
    logic [3:0] direction;
    logic       dir_valid;
    logic [3:0] btn_level;
    logic       dropped;

    int checks = 0;
    int errors = 0;

    direction_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH(20),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .dir_ready(dir_ready),
        .direction(direction),
        .dir_valid(dir_valid),
        .btn_level(btn_level),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Model: a debounced level flips once the last D synchronised samples all
    // disagree with it; samples reach the debouncer three edges after capture.
    int         t;
    logic [3:0] hist [0:8191];
    logic [3:0] m_level;
    logic [3:0] m_ev;
    logic [3:0] m_seen;
    logic [3:0] m_dir;
    logic       m_drop;

    function automatic logic [3:0] smp(input int k);
        return (k < 1) ? 4'b0000 : hist[k];
    endfunction

    task automatic model_reset();
        t       = 0;
        m_level = '0;
        m_ev    = '0;
        m_seen  = '0;
        m_dir   = '0;
        m_drop  = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] new_ev;
        logic [3:0] s;
        logic       diff;
        t = t + 1;
        hist[t] = ~{btn_right, btn_left, btn_down, btn_up};
        m_drop = 1'b0;
        if (m_dir == 4'b0000) begin
            if (m_ev != 4'b0000) begin
                for (int i = 3; i >= 0; i--) begin
                    if (m_ev[i]) m_dir = 4'b0001 << i;
                end
                m_drop = ($countones(m_ev) > 1);
            end
        end else begin
            if (m_ev != 4'b0000) m_drop = 1'b1;
            if (dir_ready) m_dir = 4'b0000;
        end
        if (t >= 4) m_seen = m_seen | ~smp(t - 3);
        new_ev = '0;
        for (int i = 0; i < 4; i++) begin
            diff = 1'b1;
            for (int j = 3; j <= D + 2; j++) begin
                s = smp(t - j);
                if (s[i] == m_level[i]) diff = 1'b0;
            end
            if (diff) begin
                if (!m_level[i] && m_seen[i]) new_ev[i] = 1'b1;
                m_level[i] = ~m_level[i];
            end
        end
        m_ev = new_ev;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("direction", {28'd0, direction}, {28'd0, m_dir});
        check("dir_valid", {31'd0, dir_valid}, {31'd0, (m_dir != 4'b0000)});
        check("btn_level", {28'd0, btn_level}, {28'd0, m_level});
        check("dropped", {31'd0, dropped}, {31'd0, m_drop});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ack();
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
    endtask

    int n_cmd;
    int n_nonzero;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ticks(10);

        // Clean press of left, consumer not ready
        btn_left = 1'b0;
        ticks(7);
        check("left_level_edge6", {28'd0, btn_level}, 32'h4);
        check("left_dir_edge6", {28'd0, direction}, 32'h0);
        tick();
        check("left_dir_edge7", {28'd0, direction}, 32'h4);
        check("left_valid_edge7", {31'd0, dir_valid}, 32'h1);
        ticks(50);
        check("left_held", {28'd0, direction}, 32'h4);
        ack();
        check("left_cleared", {28'd0, direction}, 32'h0);
        btn_left = 1'b1;
        ticks(12);

        // Async reset while a command is pending with up held
        btn_up = 1'b0;
        ticks(12);
        check("up_pending", {28'd0, direction}, 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_direction", {28'd0, direction}, 32'h0);
        check("rst_valid", {31'd0, dir_valid}, 32'h0);
        check("rst_level", {28'd0, btn_level}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_nonzero = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (direction != 4'b0000) n_nonzero++;
        end
        check("no_cmd_after_rst", n_nonzero, 0);
        btn_up = 1'b1;
        ticks(12);

        // Bouncing right button
        n_nonzero = 0;
        for (int c = 0; c < 20; c++) begin
            btn_right = ((c / 2) % 2) != 0;
            tick();
            if (direction != 4'b0000) n_nonzero++;
        end
        check("bounce_no_cmd", n_nonzero, 0);
        btn_right = 1'b0;
        ticks(7);
        check("bounce_edge6", {28'd0, direction}, 32'h0);
        tick();
        check("bounce_edge7", {28'd0, direction}, 32'h8);
        ack();
        btn_right = 1'b1;
        ticks(12);

        // Simultaneous up and down
        btn_up = 1'b0;
        btn_down = 1'b0;
        ticks(7);
        check("simul_pre_dropped", {31'd0, dropped}, 32'h0);
        tick();
        check("simul_dir", {28'd0, direction}, 32'h1);
        check("simul_dropped", {31'd0, dropped}, 32'h1);
        tick();
        check("simul_dropped_once", {31'd0, dropped}, 32'h0);
        ack();
        btn_up = 1'b1;
        btn_down = 1'b1;
        ticks(12);

        // Pending overflow: right pressed while down command waits
        btn_down = 1'b0;
        ticks(8);
        check("ovf_pending", {28'd0, direction}, 32'h2);
        btn_right = 1'b0;
        ticks(8);
        check("ovf_dir_kept", {28'd0, direction}, 32'h2);
        check("ovf_dropped", {31'd0, dropped}, 32'h1);
        tick();
        check("ovf_dropped_once", {31'd0, dropped}, 32'h0);
        ack();
        n_nonzero = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (direction != 4'b0000) n_nonzero++;
        end
        check("ovf_no_late_cmd", n_nonzero, 0);
        btn_down = 1'b1;
        btn_right = 1'b1;
        ticks(12);

        // Hold and repeat with consumer always ready
        dir_ready = 1'b1;
        btn_down = 1'b0;
        n_cmd = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (direction == 4'b0010) n_cmd++;
        end
        check("hold_one_cmd", n_cmd, 1);
        btn_down = 1'b1;
        ticks(10);
        btn_down = 1'b0;
        n_cmd = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (direction == 4'b0010) n_cmd++;
        end
        check("repeat_cmd", n_cmd, 1);
        btn_down = 1'b1;
        dir_ready = 1'b0;
        ticks(12);

        // Random button activity and consumer readiness
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: btn_up = ~btn_up;
                    1: btn_down = ~btn_down;
                    2: btn_left = ~btn_left;
                    default: btn_right = ~btn_right;
                endcase
            end
            dir_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
